mux_nto1_rr: RTL and testbench
==============================

Name: mux_nto1_rr

Overview:
Parametrised N-input registered data multiplexer with valid/ready handshakes on every channel. It is the successor to the combinational 2:1 4-bit mux.
- Selects one requesting input per beat, in fixed-select or round-robin mode.
- Registers the chosen beat into a one-entry output stage.
- Sits between multiple producers and one shared consumer in the data-routing path.

Parameters:
WIDTH, 4, data bits per channel
NCH, 4, number of input channels (>=2)
SELW, $clog2(NCH), width of select/channel-index fields (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR)
sel  input  SELW  channel index used in fixed mode
in_data  input  NCH*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready; one-hot or zero
out_data  output  WIDTH  registered selected data
out_valid  output  1  output stage holds a beat
out_ready  input  1  consumer ready
out_ch  output  SELW  index of the channel that produced out_data

Behaviour:
- Reset is synchronous and active-low; clock is clk.
- Reset values when rst_n=0 at a clock edge: out_valid=0, out_data=0, out_ch=0, rr pointer=NCH-1 (so channel 0 has first priority). in_ready is combinational and is 0 while out_valid=1 and out_ready=0.
- Two-state output stage: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid | out_ready.
- Grant (combinational), at most one bit set:
  - MODE_FIXED: grant[sel] = in_valid[sel]. If sel >= NCH, grant = 0.
  - MODE_RR: first i with in_valid[i]=1, searching ptr+1, ptr+2, ... and wrapping modulo NCH.
- in_ready[i] = grant[i] & load_en. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On transfer: out_data <= channel data, out_ch <= i, out_valid <= 1. In MODE_RR, ptr <= i. In MODE_FIXED, ptr is unchanged.
- Drain without a new transfer (out_valid & out_ready, no grant): out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: back-to-back beats, full throughput of one beat per cycle.
- Latency: one cycle from an accepted input to out_valid.
- Stall: while out_valid=1 and out_ready=0, out_data and out_ch are stable and every in_ready is 0.
- Changing mode or sel affects only the next grant, never a beat already held.
- NCH not a power of 2: the rr wrap skips indices >= NCH.
- Reset asserted mid-stall drops the held beat; no input is acknowledged in a reset cycle.

Optional Feature:
Macro MUX_PKT_LOCK_EN.
- Enabled: adds ports in_last (input, NCH) and out_last (output, reset 0, registered alongside out_data).
  - After a transfer with in_last=0, grant is locked to that channel, in both modes, until a transfer with in_last=1.
  - While locked, other channels are not granted even if valid.
  - Reset clears the lock.
- Disabled: neither port exists and every beat is arbitrated independently.

Decomposition:
- Shared package mux_pkg: localparams MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a function for the rotating first-one search.
- One sub-module, rr_arbiter (parameter NCH): holds ptr and produces a one-hot grant from a request vector with an advance enable.
- The top level holds the output register and the fixed-mode path.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout.
2. MODE_FIXED, sel=2, in_data ch2=4'hA, all valid, out_ready=1 -> only in_ready[2]=1; next cycle out_data=4'hA, out_ch=2.
3. MODE_RR, all 4 channels valid with data 1,2,3,4, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
4. MODE_RR, only ch1 and ch3 valid, out_ready=0 for 3 cycles after the first beat -> out_data frozen at the ch1 value, in_ready=0; after release, the next beat comes from ch3.
5. MODE_FIXED with sel=3 but in_valid[3]=0 and the other channels valid -> no transfer, out_valid falls to 0 after drain.
6. With MUX_PKT_LOCK_EN, MODE_RR: ch0 sends a 3-beat packet (in_last on beat 3) while ch1 is valid -> out_ch=0,0,0 then 1, and out_last=1 on the third beat only.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered mux: mode encodings, output-stage
// states and the rotating first-one search used by the round-robin arbiter.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_CH  = 64;
    localparam int MAX_CHW = 6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    // Index of the first set bit of req searching ptr+1, ptr+2, ... modulo nch,
    // or -1 when nothing is requesting. Indices >= nch are never visited.
    function automatic int rr_first_one(
        input logic [MAX_CH-1:0] req,
        input int                ptr,
        input int                nch
    );
        int idx;
        int j;
        idx = -1;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= nch) begin
                j = ptr + k;
                if (j >= nch) begin
                    j = j - nch;
                end
                if (req[j[MAX_CHW-1:0]]) begin
                    idx = j;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr.
// ptr moves to the granted index only when adv is asserted.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [NCH-1:0] grant
);

    logic [SELW-1:0] ptr_q;
    int              win;

    always_comb begin
        win = rr_first_one(MAX_CH'(req), int'(ptr_q), NCH);
        for (int i = 0; i < NCH; i++) begin
            grant[i] = (win == i);
        end
    end

    // Reset to the last channel so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= SELW'(NCH - 1);
        end else if (adv && (win >= 0)) begin
            ptr_q <= SELW'(win);
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 registered valid/ready mux, fixed-select or round-robin, one-cycle latency.
// Optional packet lock (macro MUX_PKT_LOCK_EN) holds the grant until in_last.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
`ifdef MUX_PKT_LOCK_EN
    ,
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last
`endif
);

    stage_e          state_q;
    stage_e          state_d;
    logic            load_en;
    logic            lock_hold;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  fixed_grant;
    logic [NCH-1:0]  rr_grant;
    logic [NCH-1:0]  grant;
    logic            xfer;
    logic [SELW-1:0] xfer_ch;
    logic [WIDTH-1:0] xfer_data;

`ifdef MUX_PKT_LOCK_EN
    logic            locked_q;
    logic [SELW-1:0] lock_ch_q;
    logic            xfer_last;

    // Mid-packet, only the owning channel may request, in either mode.
    always_comb begin
        lock_hold = locked_q;
        for (int i = 0; i < NCH; i++) begin
            req[i] = in_valid[i] & (!locked_q | (lock_ch_q == SELW'(i)));
        end
    end
`else
    always_comb begin
        lock_hold = 1'b0;
        req       = in_valid;
    end
`endif

    assign load_en = (state_q == ST_EMPTY) | out_ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            fixed_grant[i] = req[i] & (lock_hold | (sel == SELW'(i)));
        end
    end

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (xfer & (mode == MODE_RR)),
        .grant (rr_grant)
    );

    assign grant    = (mode == MODE_RR) ? rr_grant : fixed_grant;
    assign in_ready = grant & {NCH{load_en & rst_n}};
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        xfer_ch   = '0;
        xfer_data = '0;
`ifdef MUX_PKT_LOCK_EN
        xfer_last = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (in_ready[i]) begin
                xfer_ch   = SELW'(i);
                xfer_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_PKT_LOCK_EN
                xfer_last = in_last[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (xfer) state_d = ST_FULL;
                      else if (out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
    end

    // Payload only moves on a transfer; a plain drain leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
        end else if (xfer) begin
            out_data <= xfer_data;
            out_ch   <= xfer_ch;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_last  <= 1'b0;
            locked_q  <= 1'b0;
            lock_ch_q <= '0;
        end else if (xfer) begin
            out_last  <= xfer_last;
            locked_q  <= !xfer_last;
            lock_ch_q <= xfer_ch;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: directed vector table, packet-lock sequence (with
// MUX_PKT_LOCK_EN) and randomized traffic against a behavioural model.
module tb_mux_nto1_rr;

    localparam int NCH   = 4;
    localparam int WIDTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_ch;
`ifdef MUX_PKT_LOCK_EN
    logic [3:0]  in_last = '0;
    logic        out_last;
`endif

    always #5 clk = ~clk;

    mux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [3:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_valid, m_data, m_ch, m_ptr, m_locked, m_lock_ch, m_last;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic md, input logic [1:0] s,
                                input logic [3:0] v, input logic [15:0] d, input logic ordy,
                                input logic [3:0] erdy, input logic eov, input logic [3:0] eod,
                                input logic [1:0] eoc);
        vec_t t;
        t.rst_n = r; t.mode = md; t.sel = s; t.valid = v; t.data = d; t.ordy = ordy;
        t.exp_rdy = erdy; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
        return t;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = NCH - 1;
        m_locked = 0; m_lock_ch = 0; m_last = 0;
    endfunction

    // Channel the rules allow to transfer this cycle, -1 if none.
    function automatic int model_pick();
        int cand;
        cand = -1;
        if (!rst_n) return -1;
        if (m_valid != 0 && !out_ready) return -1;
        if (m_locked != 0) begin
            if (in_valid[m_lock_ch]) cand = m_lock_ch;
        end else if (mode == 1'b0) begin
            if (in_valid[sel]) cand = int'(sel);
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (in_valid[c]) begin
                    cand = c;
                    break;
                end
            end
        end
        return cand;
    endfunction

    function automatic void model_update(input int g);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = (in_data >> (WIDTH * g)) & 15;
            m_ch    = g;
            if (mode == 1'b1) m_ptr = g;
`ifdef MUX_PKT_LOCK_EN
            m_last    = in_last[g] ? 1 : 0;
            m_locked  = in_last[g] ? 0 : 1;
            m_lock_ch = g;
`endif
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end
    endfunction

    task automatic run_cycle(input bit from_tbl, input vec_t v, input string tag);
        int g;
        int e_rdy;
        #1;
        g = model_pick();
        e_rdy = from_tbl ? int'(v.exp_rdy) : ((g >= 0) ? (1 << g) : 0);
        check({tag, ".in_ready"}, int'(in_ready), e_rdy);
        @(posedge clk);
        model_update(g);
        #1;
        if (from_tbl) begin
            check({tag, ".out_valid"}, int'(out_valid), int'(v.exp_ov));
            check({tag, ".out_data"},  int'(out_data),  int'(v.exp_od));
            check({tag, ".out_ch"},    int'(out_ch),    int'(v.exp_oc));
        end else begin
            check({tag, ".out_valid"}, int'(out_valid), m_valid);
            check({tag, ".out_data"},  int'(out_data),  m_data);
            check({tag, ".out_ch"},    int'(out_ch),    m_ch);
`ifdef MUX_PKT_LOCK_EN
            check({tag, ".out_last"},  int'(out_last),  m_last);
`endif
        end
    endtask

    task automatic apply(input vec_t v);
        rst_n     = v.rst_n;
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.valid;
        in_data   = v.data;
        out_ready = v.ordy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t tbl[20];
        vec_t dummy;

        // rst mode sel valid data ordy | exp_rdy ov od oc
        tbl[0]  = mk(0, 0, 0, 4'hF, 16'h4321, 1, 4'b0000, 0, 4'h0, 0);
        tbl[1]  = mk(0, 0, 0, 4'hF, 16'h4321, 1, 4'b0000, 0, 4'h0, 0);
        tbl[2]  = mk(1, 0, 2, 4'hF, 16'hDA21, 1, 4'b0100, 1, 4'hA, 2);
        tbl[3]  = mk(1, 0, 3, 4'h7, 16'hDA21, 1, 4'b0000, 0, 4'hA, 2);
        tbl[4]  = mk(1, 0, 3, 4'h7, 16'hDA21, 1, 4'b0000, 0, 4'hA, 2);
        tbl[5]  = mk(1, 1, 0, 4'hF, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);
        tbl[6]  = mk(1, 1, 0, 4'hF, 16'h4321, 1, 4'b0010, 1, 4'h2, 1);
        tbl[7]  = mk(1, 1, 0, 4'hF, 16'h4321, 1, 4'b0100, 1, 4'h3, 2);
        tbl[8]  = mk(1, 1, 0, 4'hF, 16'h4321, 1, 4'b1000, 1, 4'h4, 3);
        tbl[9]  = mk(1, 1, 0, 4'hF, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);
        tbl[10] = mk(1, 1, 0, 4'hA, 16'h4321, 1, 4'b0010, 1, 4'h2, 1);
        tbl[11] = mk(1, 1, 0, 4'hA, 16'h4321, 0, 4'b0000, 1, 4'h2, 1);
        tbl[12] = mk(1, 0, 3, 4'hA, 16'h4321, 0, 4'b0000, 1, 4'h2, 1);
        tbl[13] = mk(1, 1, 0, 4'hA, 16'h4321, 0, 4'b0000, 1, 4'h2, 1);
        tbl[14] = mk(1, 1, 0, 4'hA, 16'h4321, 1, 4'b1000, 1, 4'h4, 3);
        tbl[15] = mk(1, 1, 0, 4'h0, 16'h4321, 1, 4'b0000, 0, 4'h4, 3);
        tbl[16] = mk(1, 1, 0, 4'h2, 16'h4321, 1, 4'b0010, 1, 4'h2, 1);
        tbl[17] = mk(1, 1, 0, 4'hF, 16'h4321, 0, 4'b0000, 1, 4'h2, 1);
        tbl[18] = mk(0, 1, 0, 4'hF, 16'h4321, 1, 4'b0000, 0, 4'h0, 0);
        tbl[19] = mk(1, 1, 0, 4'hF, 16'h4321, 1, 4'b0001, 1, 4'h1, 0);

        model_reset();
        for (int i = 0; i < 20; i++) begin
            apply(tbl[i]);
            run_cycle(1'b1, tbl[i], $sformatf("vec%0d", i));
        end

        dummy = tbl[0];

`ifdef MUX_PKT_LOCK_EN
        begin
            int exp_ch[4]   = '{0, 0, 0, 1};
            int exp_last[4] = '{0, 0, 1, 0};
            int lasts[4]    = '{0, 0, 1, 0};
            apply(tbl[0]);
            in_last = '0;
            run_cycle(1'b0, dummy, "lock.rst");
            rst_n = 1; mode = 1; out_ready = 1;
            in_valid = 4'b0011; in_data = 16'h0095;
            for (int b = 0; b < 4; b++) begin
                in_last = lasts[b][0] ? 4'b0001 : 4'b0000;
                run_cycle(1'b0, dummy, $sformatf("lock%0d", b));
                check($sformatf("lock%0d.ch", b), int'(out_ch), exp_ch[b]);
                check($sformatf("lock%0d.last", b), int'(out_last), exp_last[b]);
            end
        end
`endif

        for (int n = 0; n < 500; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX_PKT_LOCK_EN
            in_last   = 4'($urandom_range(0, 15));
`endif
            run_cycle(1'b0, dummy, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
